compteur_rounds_blocks: RTL and testbench
=========================================

Name: compteur_rounds_blocks

Overview:
- Parametrised successor to the ASCON block counter: one block sequencing permutation rounds and counting processed data blocks.
- Accepts a start request in either initialisation mode (p^a) or data mode (p^b) and produces the round index for the round-constant logic.
- Increments a programmable-width block counter on completion of each data-mode permutation.
- Sits between the ASCON control FSM and the permutation datapath.

Parameters:
- ROUNDS_A, 12, rounds in init/finalisation mode; legal 1..12
- ROUNDS_B, 6, rounds in data mode; legal 1..12
- BLK_W, 4, block counter width in bits; legal 1..16
- MAX_BLOCKS, 16, block count modulus; legal 2..2^BLK_W
- SATURATE, 0, 0 = wrap to 0 at MAX_BLOCKS, 1 = hold at MAX_BLOCKS-1

Ports:
- clock_i  in  1  system clock, rising edge
- resetb_i  in  1  asynchronous active-low reset
- start_i  in  1  start-permutation request; sampled only in IDLE
- mode_i  in  1  0 = init (ROUNDS_A), 1 = data (ROUNDS_B); sampled with start_i
- abort_i  in  1  synchronous abort of the running permutation
- clear_blk_i  in  1  synchronous clear of the block counter
- busy_o  out  1  high while in RUN
- round_o  out  4  current round index, 12-ROUNDS_x .. 11
- last_round_o  out  1  combinational; busy_o && round_o == 11
- done_o  out  1  registered one-cycle pulse after the final round
- blk_cpt_o  out  BLK_W  block count
- blk_last_o  out  1  combinational; blk_cpt_o == MAX_BLOCKS-1
- wrap_o  out  1  registered one-cycle pulse when the block counter wraps (SATURATE=0 only)

Behaviour:
- Reset values: state IDLE, round_o 0, busy_o 0, done_o 0, blk_cpt_o 0, wrap_o 0, latched mode 0.
- Reset is asynchronous and takes effect mid-operation; no done_o follows it.
- FSM has two states, IDLE and RUN.
- IDLE, start_i=1, abort_i=0:
  - next state RUN;
  - round_o <= 12-ROUNDS_A if mode_i=0, else 12-ROUNDS_B;
  - mode latched.
- RUN, round_o<11, abort_i=0: round_o <= round_o+1.
- RUN, round_o==11, abort_i=0:
  - next state IDLE, round_o <= 0, done_o <= 1 for one cycle;
  - if latched mode=1, block-counter increment event occurs on the same edge.
- Permutation latency: first round index is visible the cycle after start_i. done_o asserts ROUNDS_x+1 cycles after the start_i edge.
- Back-to-back: start_i is accepted in the cycle done_o is high, since state is already IDLE. There are no idle bubbles between permutations.
- start_i during RUN is ignored, not queued.
- abort_i (any state): next state IDLE, round_o <= 0. No done_o, no block increment. abort_i has priority over start_i and over completion.
- Block counter, priority order on each edge:
  1. clear_blk_i -> blk_cpt_o <= 0, wrap_o <= 0
  2. increment event with blk_cpt_o < MAX_BLOCKS-1 -> +1
  3. increment event at MAX_BLOCKS-1 with SATURATE=0 -> 0, wrap_o <= 1
  4. increment event at MAX_BLOCKS-1 with SATURATE=1 -> hold, wrap_o stays 0
- clear_blk_i coincident with an increment event: clear wins and the increment is lost.
- clear_blk_i does not affect the round FSM.
- Init-mode completions never change blk_cpt_o.
- wrap_o and done_o are low in every cycle not explicitly stated above.
- Arithmetic: round_o is 4-bit unsigned and never exceeds 11. blk_cpt_o is BLK_W-bit unsigned and never reaches MAX_BLOCKS.

Test Plan:
- Reset, then start_i=1, mode_i=0 -> round_o 0,1,…,11 on consecutive cycles; last_round_o high with round_o=11; done_o pulses once; blk_cpt_o stays 0.
- Default parameters, start_i with mode_i=1 three times back-to-back (each start_i in the done_o cycle) -> round_o 6..11 repeated with no gap; blk_cpt_o 1, 2, 3; done_o pulses 3 times.
- Data-mode start, abort_i at round_o=8 -> next cycle busy_o=0, round_o=0; no done_o; blk_cpt_o unchanged.
- MAX_BLOCKS=4, SATURATE=0, five data permutations -> blk_cpt_o 1,2,3,0,1; wrap_o one pulse on the 3->0 edge; blk_last_o high while the count is 3. Rerun with SATURATE=1 -> count holds at 3, wrap_o never asserted.
- clear_blk_i asserted in the cycle of the round_o=11 edge with blk_cpt_o=5 -> blk_cpt_o=0 afterwards, not 6; done_o still pulses.
- resetb_i low at round_o=9 of a data permutation -> all outputs 0 immediately, asynchronously; no done_o after release; a new start_i is then accepted normally.

Source files
------------

// File: rtl/compteur_rounds_blocks.sv
// ASCON round sequencer and data-block counter.
// Runs p^a (ROUNDS_A) or p^b (ROUNDS_B) permutations, publishes the round
// index for the round-constant logic and counts completed data-mode
// permutations modulo MAX_BLOCKS, with optional saturation.
module compteur_rounds_blocks #(
    parameter int ROUNDS_A   = 12,
    parameter int ROUNDS_B   = 6,
    parameter int BLK_W      = 4,
    parameter int MAX_BLOCKS = 16,
    parameter bit SATURATE   = 1'b0
) (
    input  logic             clock_i,
    input  logic             resetb_i,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             abort_i,
    input  logic             clear_blk_i,
    output logic             busy_o,
    output logic [3:0]       round_o,
    output logic             last_round_o,
    output logic             done_o,
    output logic [BLK_W-1:0] blk_cpt_o,
    output logic             blk_last_o,
    output logic             wrap_o
);

    // Rounds always end at index 11; shorter permutations start later.
    localparam logic [3:0]       LAST_ROUND = 4'd11;
    localparam logic [3:0]       START_A    = 4'(12 - ROUNDS_A);
    localparam logic [3:0]       START_B    = 4'(12 - ROUNDS_B);
    localparam logic [BLK_W-1:0] BLK_MAX    = BLK_W'(MAX_BLOCKS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    logic [3:0]       round_q;
    logic             mode_q;
    logic             done_q;
    logic [BLK_W-1:0] blk_cpt_q;
    logic [BLK_W-1:0] blk_cpt_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             complete;
    logic             inc_evt;

    // A permutation completes on the edge leaving round 11, unless aborted.
    assign complete = (state_q == RUN) && (round_q == LAST_ROUND) && !abort_i;
    assign inc_evt  = complete && mode_q;

    // Round FSM: start/abort/completion handling with registered done pulse.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q <= IDLE;
            round_q <= 4'd0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                round_q <= 4'd0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            state_q <= RUN;
                            mode_q  <= mode_i;
                            round_q <= mode_i ? START_B : START_A;
                        end
                    end
                    RUN: begin
                        if (complete) begin
                            state_q <= IDLE;
                            round_q <= 4'd0;
                            done_q  <= 1'b1;
                        end else begin
                            round_q <= round_q + 4'd1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        round_q <= 4'd0;
                    end
                endcase
            end
        end
    end

    // Block counter next state: clear beats increment; top value wraps or holds.
    always_comb begin
        blk_cpt_d = blk_cpt_q;
        wrap_d    = 1'b0;
        if (clear_blk_i) begin
            blk_cpt_d = '0;
        end else if (inc_evt) begin
            if (blk_cpt_q < BLK_MAX) begin
                blk_cpt_d = blk_cpt_q + 1'b1;
            end else if (!SATURATE) begin
                blk_cpt_d = '0;
                wrap_d    = 1'b1;
            end
        end
    end

    // Block counter and wrap pulse registers.
    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            blk_cpt_q <= '0;
            wrap_q    <= 1'b0;
        end else begin
            blk_cpt_q <= blk_cpt_d;
            wrap_q    <= wrap_d;
        end
    end

    assign busy_o       = (state_q == RUN);
    assign round_o      = round_q;
    assign last_round_o = busy_o && (round_q == LAST_ROUND);
    assign done_o       = done_q;
    assign blk_cpt_o    = blk_cpt_q;
    assign blk_last_o   = (blk_cpt_q == BLK_MAX);
    assign wrap_o       = wrap_q;

endmodule

// File: tb/tb_compteur_rounds_blocks.sv
// Directed bench for compteur_rounds_blocks: one default instance plus two
// MAX_BLOCKS=4 instances (wrapping and saturating) sharing the same stimulus.
module tb_compteur_rounds_blocks;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       start = 1'b0;
    logic       mode = 1'b0;
    logic       abort = 1'b0;
    logic       clear_blk = 1'b0;

    logic       busy_a, last_a, done_a, blast_a, wrap_a;
    logic [3:0] round_a, blk_a;
    logic       busy_b, last_b, done_b, blast_b, wrap_b;
    logic [3:0] round_b, blk_b;
    logic       busy_c, last_c, done_c, blast_c, wrap_c;
    logic [3:0] round_c, blk_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    compteur_rounds_blocks dut_a (
        .clock_i(clk), .resetb_i(resetb), .start_i(start), .mode_i(mode),
        .abort_i(abort), .clear_blk_i(clear_blk), .busy_o(busy_a),
        .round_o(round_a), .last_round_o(last_a), .done_o(done_a),
        .blk_cpt_o(blk_a), .blk_last_o(blast_a), .wrap_o(wrap_a)
    );

    compteur_rounds_blocks #(.MAX_BLOCKS(4), .SATURATE(1'b0)) dut_b (
        .clock_i(clk), .resetb_i(resetb), .start_i(start), .mode_i(mode),
        .abort_i(abort), .clear_blk_i(clear_blk), .busy_o(busy_b),
        .round_o(round_b), .last_round_o(last_b), .done_o(done_b),
        .blk_cpt_o(blk_b), .blk_last_o(blast_b), .wrap_o(wrap_b)
    );

    compteur_rounds_blocks #(.MAX_BLOCKS(4), .SATURATE(1'b1)) dut_c (
        .clock_i(clk), .resetb_i(resetb), .start_i(start), .mode_i(mode),
        .abort_i(abort), .clear_blk_i(clear_blk), .busy_o(busy_c),
        .round_o(round_c), .last_round_o(last_c), .done_o(done_c),
        .blk_cpt_o(blk_c), .blk_last_o(blast_c), .wrap_o(wrap_c)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one permutation and walk its rounds; returns in the done cycle.
    task automatic run_perm(input logic m, input int first);
        start = 1'b1;
        mode  = m;
        step();
        start = 1'b0;
        for (int r = first; r <= 11; r++) begin
            check_val("round", 32'(round_a), 32'(r));
            check_val("busy", 32'(busy_a), 32'd1);
            check_val("last_round", 32'(last_a), 32'(r == 11));
            check_val("done_low", 32'(done_a), 32'd0);
            step();
        end
        check_val("done_pulse", 32'(done_a), 32'd1);
        check_val("busy_end", 32'(busy_a), 32'd0);
        check_val("round_end", 32'(round_a), 32'd0);
    endtask

    initial begin
        // Reset state
        #12;
        check_val("rst_busy", 32'(busy_a), 32'd0);
        check_val("rst_round", 32'(round_a), 32'd0);
        check_val("rst_done", 32'(done_a), 32'd0);
        check_val("rst_blk", 32'(blk_a), 32'd0);
        check_val("rst_wrap", 32'(wrap_a), 32'd0);
        check_val("rst_blast", 32'(blast_a), 32'd0);
        resetb = 1'b1;
        step();
        step();

        // Init-mode permutation: rounds 0..11, counter untouched
        run_perm(1'b0, 0);
        check_val("init_blk", 32'(blk_a), 32'd0);

        // Five back-to-back data permutations, each started in the done cycle
        for (int k = 1; k <= 5; k++) begin
            run_perm(1'b1, 6);
            check_val("blk_a", 32'(blk_a), 32'(k));
            check_val("blk_b", 32'(blk_b), 32'(k % 4));
            check_val("blk_c", 32'(blk_c), 32'((k < 3) ? k : 3));
            check_val("wrap_a", 32'(wrap_a), 32'd0);
            check_val("wrap_b", 32'(wrap_b), 32'(k == 4));
            check_val("wrap_c", 32'(wrap_c), 32'd0);
            check_val("blast_a", 32'(blast_a), 32'd0);
            check_val("blast_b", 32'(blast_b), 32'(k == 3));
            check_val("blast_c", 32'(blast_c), 32'(k >= 3));
            check_val("done_b", 32'(done_b), 32'd1);
        end
        step();
        check_val("done_after", 32'(done_a), 32'd0);
        check_val("wrap_b_after", 32'(wrap_b), 32'd0);
        check_val("blk_a_idle", 32'(blk_a), 32'd5);

        // Abort at round 8 of a data permutation
        start = 1'b1;
        mode  = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check_val("abort_round8", 32'(round_a), 32'd8);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("abort_busy", 32'(busy_a), 32'd0);
        check_val("abort_round", 32'(round_a), 32'd0);
        check_val("abort_done", 32'(done_a), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check_val("abort_no_done", 32'(done_a), 32'd0);
        end
        check_val("abort_blk", 32'(blk_a), 32'd5);

        // Clear coincident with completion: clear wins, done still pulses
        start = 1'b1;
        mode  = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check_val("clr_round11", 32'(round_a), 32'd11);
        clear_blk = 1'b1;
        step();
        clear_blk = 1'b0;
        check_val("clr_done", 32'(done_a), 32'd1);
        check_val("clr_blk_a", 32'(blk_a), 32'd0);
        check_val("clr_blk_c", 32'(blk_c), 32'd0);
        check_val("clr_wrap_b", 32'(wrap_b), 32'd0);
        step();

        // Asynchronous reset at round 9
        start = 1'b1;
        mode  = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check_val("rst_round9", 32'(round_a), 32'd9);
        #2 resetb = 1'b0;
        #1;
        check_val("arst_busy", 32'(busy_a), 32'd0);
        check_val("arst_round", 32'(round_a), 32'd0);
        check_val("arst_done", 32'(done_a), 32'd0);
        check_val("arst_last", 32'(last_a), 32'd0);
        step();
        step();
        #3 resetb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check_val("arst_no_done", 32'(done_a), 32'd0);
            check_val("arst_idle", 32'(busy_a), 32'd0);
        end
        run_perm(1'b1, 6);
        check_val("post_rst_blk", 32'(blk_a), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
